// File: rtl/ps2_mouse_init_ctrl.sv
// PS/2 mouse initialisation sequencer: reset, IntelliMouse wheel detect and stream enable,
// with reply checking, per-wait timeouts and whole-sequence retries.
module ps2_mouse_init_ctrl #(
    parameter int ACK_TIMEOUT = 1_000_000,
    parameter int BAT_TIMEOUT = 50_000_000,
    parameter int RETRY_MAX   = 3
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       iStart,
    output logic       oTxReq,
    output logic [7:0] oTxByte,
    input  logic       iTxDone,
    input  logic       iTxErr,
    input  logic       iRxValid,
    input  logic [7:0] iRxByte,
    output logic [1:0] oEn,
    output logic       oDone,
    output logic       oFail,
    output logic       oWheel,
    output logic [1:0] oRetries
);

    localparam int TMAX = (BAT_TIMEOUT > ACK_TIMEOUT) ? BAT_TIMEOUT : ACK_TIMEOUT;
    localparam int TW   = $clog2(TMAX) + 1;

    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_SEND       = 4'd1;
    localparam logic [3:0] S_WAIT_TX    = 4'd2;
    localparam logic [3:0] S_WAIT_ACK   = 4'd3;
    localparam logic [3:0] S_WAIT_BAT   = 4'd4;
    localparam logic [3:0] S_WAIT_BATID = 4'd5;
    localparam logic [3:0] S_WAIT_DEVID = 4'd6;
    localparam logic [3:0] S_NEXT       = 4'd7;
    localparam logic [3:0] S_DONE       = 4'd8;
    localparam logic [3:0] S_FAIL       = 4'd9;

    function automatic logic [7:0] cmd_byte(input logic [3:0] idx);
        case (idx)
            4'd0:    cmd_byte = 8'hFF;
            4'd1:    cmd_byte = 8'hF3;
            4'd2:    cmd_byte = 8'hC8;
            4'd3:    cmd_byte = 8'hF3;
            4'd4:    cmd_byte = 8'h64;
            4'd5:    cmd_byte = 8'hF3;
            4'd6:    cmd_byte = 8'h50;
            4'd7:    cmd_byte = 8'hF2;
            4'd8:    cmd_byte = 8'hF4;
            default: cmd_byte = 8'h00;
        endcase
    endfunction

    logic [3:0]    state, state_n;
    logic [3:0]    step, step_n;
    logic          resent, resent_n;
    logic [TW-1:0] timer, timer_n;
    logic          tx_req_n, done_n, fail_n, wheel_n;
    logic [7:0]    tx_byte_n;
    logic [1:0]    en_n, retries_n, retries_inc;
    logic          err, load_ack, load_bat;

    assign retries_inc = (oRetries == 2'd3) ? 2'd3 : oRetries + 2'd1;

    always_comb begin
        state_n   = state;
        step_n    = step;
        resent_n  = resent;
        tx_req_n  = oTxReq;
        tx_byte_n = oTxByte;
        en_n      = oEn;
        done_n    = oDone;
        fail_n    = oFail;
        wheel_n   = oWheel;
        retries_n = oRetries;
        err       = 1'b0;
        load_ack  = 1'b0;
        load_bat  = 1'b0;

        case (state)
            S_IDLE: begin
                state_n  = S_SEND;
                step_n   = 4'd0;
                resent_n = 1'b0;
            end
            S_SEND: begin
                tx_req_n  = 1'b1;
                tx_byte_n = cmd_byte(step);
                state_n   = S_WAIT_TX;
                load_ack  = 1'b1;
            end
            S_WAIT_TX: begin
                if (iTxErr) begin
                    err = 1'b1;
                end else if (iTxDone) begin
                    tx_req_n = 1'b0;
                    state_n  = S_WAIT_ACK;
                    load_ack = 1'b1;
                end else if (timer == '0) begin
                    err = 1'b1;
                end
            end
            S_WAIT_ACK: begin
                if (iRxValid) begin
                    if (iRxByte == 8'hFA) begin
                        if (step == 4'd0) begin
                            state_n  = S_WAIT_BAT;
                            load_bat = 1'b1;
                        end else if (step == 4'd7) begin
                            state_n  = S_WAIT_DEVID;
                            load_ack = 1'b1;
                        end else begin
                            state_n = S_NEXT;
                        end
                    end else if (iRxByte == 8'hFE && !resent) begin
                        resent_n = 1'b1;
                        state_n  = S_SEND;
                    end else begin
                        err = 1'b1;
                    end
                end else if (timer == '0) begin
                    err = 1'b1;
                end
            end
            S_WAIT_BAT: begin
                if (iRxValid) begin
                    if (iRxByte == 8'hAA) begin
                        state_n  = S_WAIT_BATID;
                        load_ack = 1'b1;
                    end else begin
                        err = 1'b1;
                    end
                end else if (timer == '0) begin
                    err = 1'b1;
                end
            end
            S_WAIT_BATID: begin
                if (iRxValid) begin
                    if (iRxByte == 8'h00) state_n = S_NEXT;
                    else                  err     = 1'b1;
                end else if (timer == '0) begin
                    err = 1'b1;
                end
            end
            S_WAIT_DEVID: begin
                if (iRxValid) begin
                    if (iRxByte == 8'h03) begin
                        wheel_n = 1'b1;
                        state_n = S_NEXT;
                    end else if (iRxByte == 8'h00) begin
                        wheel_n = 1'b0;
                        state_n = S_NEXT;
                    end else begin
                        err = 1'b1;
                    end
                end else if (timer == '0) begin
                    err = 1'b1;
                end
            end
            S_NEXT: begin
                resent_n = 1'b0;
                if (step == 4'd8) begin
                    state_n = S_DONE;
                    done_n  = 1'b1;
                    en_n    = {oWheel, 1'b1};
                end else begin
                    step_n  = step + 4'd1;
                    state_n = S_SEND;
                end
            end
            S_DONE, S_FAIL: begin
                if (iStart) begin
                    state_n   = S_IDLE;
                    done_n    = 1'b0;
                    fail_n    = 1'b0;
                    en_n      = 2'b00;
                    wheel_n   = 1'b0;
                    retries_n = 2'd0;
                end
            end
            default: state_n = S_IDLE;
        endcase

        // Any error aborts the current attempt; a pending request is always withdrawn.
        if (err) begin
            tx_req_n  = 1'b0;
            retries_n = retries_inc;
            if (int'(retries_inc) < RETRY_MAX) begin
                state_n  = S_SEND;
                step_n   = 4'd0;
                resent_n = 1'b0;
                wheel_n  = 1'b0;
            end else begin
                state_n = S_FAIL;
                fail_n  = 1'b1;
                en_n    = 2'b00;
            end
        end

        if (load_bat)                timer_n = TW'(BAT_TIMEOUT - 1);
        else if (load_ack)           timer_n = TW'(ACK_TIMEOUT - 1);
        else if (timer != '0)        timer_n = timer - 1'b1;
        else                         timer_n = timer;
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state    <= S_IDLE;
            step     <= 4'd0;
            resent   <= 1'b0;
            timer    <= '0;
            oTxReq   <= 1'b0;
            oTxByte  <= 8'h00;
            oEn      <= 2'b00;
            oDone    <= 1'b0;
            oFail    <= 1'b0;
            oWheel   <= 1'b0;
            oRetries <= 2'd0;
        end else begin
            state    <= state_n;
            step     <= step_n;
            resent   <= resent_n;
            timer    <= timer_n;
            oTxReq   <= tx_req_n;
            oTxByte  <= tx_byte_n;
            oEn      <= en_n;
            oDone    <= done_n;
            oFail    <= fail_n;
            oWheel   <= wheel_n;
            oRetries <= retries_n;
        end
    end

endmodule

// File: tb/tb_ps2_mouse_init_ctrl.sv
// Bench for ps2_mouse_init_ctrl: a randomised-delay PS/2 device model answers each command,
// and a sequence-level model predicts the transmit log and final status.
module tb_ps2_mouse_init_ctrl;

    localparam int ACK_T = 20;
    localparam int BAT_T = 40;
    localparam int RMAX  = 3;

    localparam int K_NONE   = 0;
    localparam int K_FE1    = 1;
    localparam int K_FE2    = 2;
    localparam int K_BAD    = 3;
    localparam int K_SILENT = 4;
    localparam int K_BATFC  = 5;
    localparam int K_BADID  = 6;
    localparam int K_TXERR  = 7;

    logic       CLOCK = 1'b0;
    logic       RESET, iStart, iTxDone, iTxErr, iRxValid;
    logic [7:0] iRxByte;
    logic       oTxReq, oDone, oFail, oWheel;
    logic [7:0] oTxByte;
    logic [1:0] oEn, oRetries;

    int checks = 0;
    int errors = 0;

    logic [7:0] cmd_list [9] = '{8'hFF, 8'hF3, 8'hC8, 8'hF3, 8'h64, 8'hF3, 8'h50, 8'hF2, 8'hF4};

    int         cfg_kind, cfg_step, cfg_attempts, cfg_abort_step;
    logic [7:0] cfg_id, cfg_bad;

    logic [7:0] tx_log[$];
    logic [7:0] exp_log[$];
    int         gaps[$];
    int         late_drop;
    int         exp_retries;
    bit         exp_done, exp_fail, exp_wheel;

    ps2_mouse_init_ctrl #(
        .ACK_TIMEOUT(ACK_T),
        .BAT_TIMEOUT(BAT_T),
        .RETRY_MAX  (RMAX)
    ) dut (
        .CLOCK   (CLOCK),
        .RESET   (RESET),
        .iStart  (iStart),
        .oTxReq  (oTxReq),
        .oTxByte (oTxByte),
        .iTxDone (iTxDone),
        .iTxErr  (iTxErr),
        .iRxValid(iRxValid),
        .iRxByte (iRxByte),
        .oEn     (oEn),
        .oDone   (oDone),
        .oFail   (oFail),
        .oWheel  (oWheel),
        .oRetries(oRetries)
    );

    always #5 CLOCK = ~CLOCK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] pick_bad();
        logic [7:0] b;
        do b = 8'($urandom_range(0, 255));
        while (b == 8'h00 || b == 8'h03 || b == 8'hAA || b == 8'hFA || b == 8'hFE);
        return b;
    endfunction

    task automatic set_cfg(input int kind, input int stp, input int att, input logic [7:0] id);
        cfg_kind       = kind;
        cfg_step       = stp;
        cfg_attempts   = att;
        cfg_id         = id;
        cfg_bad        = pick_bad();
        cfg_abort_step = -1;
    endtask

    // Sequence-level prediction: walk attempts and steps, applying the configured device fault.
    task automatic model_run();
        bit err;
        bit hit;
        exp_log.delete();
        exp_retries = 0;
        exp_done    = 0;
        exp_fail    = 0;
        exp_wheel   = 0;
        for (int a = 1; a <= RMAX && !exp_done && !exp_fail; a++) begin
            err = 0;
            for (int s = 0; s < 9 && !err; s++) begin
                hit = (a <= cfg_attempts) && (s == cfg_step);
                exp_log.push_back(cmd_list[s]);
                if (hit && (cfg_kind == K_FE1 || cfg_kind == K_FE2)) exp_log.push_back(cmd_list[s]);
                if (hit && cfg_kind != K_NONE && cfg_kind != K_FE1) err = 1;
                if (s == 7 && !err && cfg_id != 8'h03 && cfg_id != 8'h00) err = 1;
            end
            if (err) begin
                exp_retries++;
                if (exp_retries >= RMAX) exp_fail = 1;
            end else begin
                exp_done  = 1;
                exp_wheel = (cfg_id == 8'h03);
            end
        end
    endtask

    function automatic logic [6:0] exp_status();
        logic [1:0] en;
        en = exp_done ? {exp_wheel, 1'b1} : 2'b00;
        return {exp_done, exp_fail, en, exp_wheel, 2'(exp_retries)};
    endfunction

    function automatic int first_diff();
        int n;
        n = (tx_log.size() < exp_log.size()) ? tx_log.size() : exp_log.size();
        for (int i = 0; i < n; i++) if (tx_log[i] !== exp_log[i]) return i;
        if (tx_log.size() != exp_log.size()) return n;
        return -1;
    endfunction

    task automatic send_byte(input logic [7:0] b, input int maxd);
        repeat ($urandom_range(0, maxd)) @(negedge CLOCK);
        iRxValid = 1'b1;
        iRxByte  = b;
        @(negedge CLOCK);
        iRxValid = 1'b0;
        iRxByte  = 8'($urandom_range(0, 255));
    endtask

    // Device model: serves transmit requests until the controller reports done/fail.
    task automatic run_device(output bit timed_out);
        int         attempt, stp, fe_cnt, cnt;
        bit         last_fe, silent, hit;
        logic [7:0] b;
        attempt = 0; stp = 0; fe_cnt = 0; last_fe = 0; silent = 0;
        tx_log.delete();
        gaps.delete();
        late_drop = 0;
        timed_out = 0;
        forever begin
            cnt = 0;
            while (!oTxReq && !oDone && !oFail && cnt < 200) begin
                @(negedge CLOCK);
                cnt++;
            end
            if (cnt >= 200) begin
                timed_out = 1;
                return;
            end
            if (!oTxReq) return;
            if (silent) gaps.push_back(cnt + 1);
            silent = 0;
            b = oTxByte;
            tx_log.push_back(b);
            if (!last_fe) begin
                if (b == 8'hFF) begin
                    attempt++;
                    stp = 0;
                end else begin
                    stp++;
                end
                fe_cnt = 0;
            end
            last_fe = 0;
            hit = (attempt <= cfg_attempts) && (stp == cfg_step);
            repeat ($urandom_range(0, 3)) @(negedge CLOCK);
            if (hit && cfg_kind == K_TXERR) begin
                iTxErr  = 1'b1;
                iTxDone = 1'($urandom_range(0, 1));
            end else begin
                iTxDone = 1'b1;
            end
            @(negedge CLOCK);
            iTxDone = 1'b0;
            iTxErr  = 1'b0;
            if (oTxReq) late_drop++;
            if (stp == cfg_abort_step) return;
            if (hit && cfg_kind == K_TXERR) continue;
            if (hit && cfg_kind == K_SILENT) begin
                silent = 1;
            end else if (hit && cfg_kind == K_FE1 && fe_cnt == 0) begin
                send_byte(8'hFE, 3);
                fe_cnt++;
                last_fe = 1;
            end else if (hit && cfg_kind == K_FE2 && fe_cnt < 2) begin
                send_byte(8'hFE, 3);
                fe_cnt++;
                last_fe = (fe_cnt < 2);
            end else if (hit && cfg_kind == K_BAD) begin
                send_byte(cfg_bad, 3);
            end else begin
                send_byte(8'hFA, 3);
                if (stp == 0) begin
                    if (hit && cfg_kind == K_BATFC) begin
                        send_byte(8'hFC, 10);
                    end else begin
                        send_byte(8'hAA, 10);
                        send_byte(8'h00, 3);
                    end
                end else if (stp == 7) begin
                    send_byte((hit && cfg_kind == K_BADID) ? cfg_bad : cfg_id, 3);
                end
            end
        end
    endtask

    task automatic run_session(output bit timed_out);
        @(negedge CLOCK);
        iStart = 1'b1;
        @(negedge CLOCK);
        iStart = 1'b0;
        run_device(timed_out);
    endtask

    task automatic test_reset();
        int cnt;
        RESET = 1'b1;
        repeat (3) @(negedge CLOCK);
        checks++;
        if ({oTxReq, oTxByte, oEn, oDone, oFail, oWheel, oRetries} !== 15'd0) begin
            errors++;
            $display("FAIL reset_values got %h need 0000", {oTxReq, oTxByte, oEn, oDone, oFail, oWheel, oRetries});
        end
        RESET = 1'b0;
        cnt = 0;
        while (!oTxReq && cnt < 10) begin
            @(negedge CLOCK);
            cnt++;
        end
        checks++;
        if (cnt != 2) begin
            errors++;
            $display("FAIL reset_to_txreq got %0d cycles need 2", cnt);
        end
        checks++;
        if (oTxByte !== 8'hFF) begin
            errors++;
            $display("FAIL first_byte got %h need ff", oTxByte);
        end
    endtask

    task automatic test_wheel();
        bit to;
        set_cfg(K_NONE, 0, 0, 8'h03);
        model_run();
        run_device(to);
        checks++;
        if (to) begin errors++; $display("FAIL wheel_timeout got stall need completion"); end
        checks++;
        if (first_diff() != -1) begin
            errors++;
            $display("FAIL wheel_txlog got %0d bytes need %0d first_diff %0d", tx_log.size(), exp_log.size(), first_diff());
        end
        checks++;
        if ({oDone, oFail, oEn, oWheel, oRetries} !== exp_status()) begin
            errors++;
            $display("FAIL wheel_status got %b need %b", {oDone, oFail, oEn, oWheel, oRetries}, exp_status());
        end
        checks++;
        if (late_drop != 0) begin errors++; $display("FAIL wheel_txreq_drop got %0d late need 0", late_drop); end
    endtask

    task automatic test_plain();
        bit to;
        set_cfg(K_NONE, 0, 0, 8'h00);
        model_run();
        run_session(to);
        checks++;
        if (to || first_diff() != -1) begin
            errors++;
            $display("FAIL plain_txlog got %0d bytes need %0d timeout %0d", tx_log.size(), exp_log.size(), to);
        end
        checks++;
        if ({oDone, oFail, oEn, oWheel, oRetries} !== 7'b1001000) begin
            errors++;
            $display("FAIL plain_status got %b need 1001000", {oDone, oFail, oEn, oWheel, oRetries});
        end
    endtask

    task automatic test_resend();
        bit to;
        set_cfg(K_FE1, 1, 1, 8'h03);
        model_run();
        run_session(to);
        checks++;
        if (to || first_diff() != -1) begin
            errors++;
            $display("FAIL fe_once_txlog got %0d bytes need %0d timeout %0d", tx_log.size(), exp_log.size(), to);
        end
        checks++;
        if ({oDone, oRetries} !== 3'b100) begin
            errors++;
            $display("FAIL fe_once_status got %b need 100", {oDone, oRetries});
        end
        set_cfg(K_FE2, 1, 1, 8'h03);
        model_run();
        run_session(to);
        checks++;
        if (to || first_diff() != -1 || tx_log.size() < 4 || tx_log[3] !== 8'hFF) begin
            errors++;
            $display("FAIL fe_twice_txlog got %0d bytes need %0d first_diff %0d", tx_log.size(), exp_log.size(), first_diff());
        end
        checks++;
        if ({oDone, oFail, oEn, oWheel, oRetries} !== 7'b1011101) begin
            errors++;
            $display("FAIL fe_twice_status got %b need 1011101", {oDone, oFail, oEn, oWheel, oRetries});
        end
    endtask

    task automatic test_no_reply();
        bit to;
        set_cfg(K_SILENT, 0, 3, 8'h03);
        model_run();
        run_session(to);
        checks++;
        if (to || first_diff() != -1) begin
            errors++;
            $display("FAIL silent_txlog got %0d bytes need %0d timeout %0d", tx_log.size(), exp_log.size(), to);
        end
        checks++;
        if ({oDone, oFail, oEn, oWheel, oRetries} !== 7'b0100011) begin
            errors++;
            $display("FAIL silent_status got %b need 0100011", {oDone, oFail, oEn, oWheel, oRetries});
        end
        checks++;
        if (gaps.size() != 2) begin
            errors++;
            $display("FAIL silent_gap_count got %0d need 2", gaps.size());
        end
        // Timeout expires ACK_T edges after iTxDone is sampled; SEND adds one edge and the
        // request is observed on the following negedge.
        foreach (gaps[i]) begin
            checks++;
            if (gaps[i] != ACK_T + 2) begin
                errors++;
                $display("FAIL silent_gap%0d got %0d need %0d", i, gaps[i], ACK_T + 2);
            end
        end
    endtask

    task automatic test_bat_retry();
        bit to;
        set_cfg(K_BATFC, 0, 1, 8'h03);
        model_run();
        run_session(to);
        checks++;
        if (to || first_diff() != -1) begin
            errors++;
            $display("FAIL bat_txlog got %0d bytes need %0d timeout %0d", tx_log.size(), exp_log.size(), to);
        end
        checks++;
        if ({oDone, oFail, oEn, oWheel, oRetries} !== 7'b1011101) begin
            errors++;
            $display("FAIL bat_status got %b need 1011101", {oDone, oFail, oEn, oWheel, oRetries});
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        set_cfg(K_FE2, 2, 1, 8'h03);
        cfg_abort_step = 8;
        run_session(to);
        repeat ($urandom_range(1, 5)) @(negedge CLOCK);
        checks++;
        if ({oWheel, oRetries} !== 3'b101) begin
            errors++;
            $display("FAIL midreset_pre got %b need 101", {oWheel, oRetries});
        end
        RESET = 1'b1;
        @(negedge CLOCK);
        checks++;
        if ({oTxReq, oTxByte, oEn, oDone, oFail, oWheel, oRetries} !== 15'd0) begin
            errors++;
            $display("FAIL midreset_values got %h need 0000", {oTxReq, oTxByte, oEn, oDone, oFail, oWheel, oRetries});
        end
        RESET = 1'b0;
        set_cfg(K_NONE, 0, 0, 8'h03);
        model_run();
        run_device(to);
        checks++;
        if (to || first_diff() != -1) begin
            errors++;
            $display("FAIL midreset_txlog got %0d bytes need %0d timeout %0d", tx_log.size(), exp_log.size(), to);
        end
        checks++;
        if ({oDone, oEn, oRetries} !== 5'b11100) begin
            errors++;
            $display("FAIL midreset_status got %b need 11100", {oDone, oEn, oRetries});
        end
    endtask

    task automatic test_restart();
        bit to;
        @(negedge CLOCK);
        iStart = 1'b1;
        @(negedge CLOCK);
        iStart = 1'b0;
        checks++;
        if ({oEn, oDone, oFail, oWheel, oRetries} !== 7'd0) begin
            errors++;
            $display("FAIL restart_clear got %b need 0000000", {oEn, oDone, oFail, oWheel, oRetries});
        end
        set_cfg(K_NONE, 0, 0, 8'h00);
        model_run();
        run_device(to);
        checks++;
        if (to || first_diff() != -1) begin
            errors++;
            $display("FAIL restart_txlog got %0d bytes need %0d timeout %0d", tx_log.size(), exp_log.size(), to);
        end
    endtask

    task automatic test_random();
        bit to;
        int kind, stp, r;
        logic [7:0] id;
        for (int it = 0; it < 12; it++) begin
            kind = $urandom_range(0, 7);
            stp  = (kind == K_BATFC) ? 0 : (kind == K_BADID) ? 7 : $urandom_range(0, 8);
            r    = $urandom_range(0, 9);
            id   = (r < 4) ? 8'h03 : (r < 8) ? 8'h00 : pick_bad();
            set_cfg(kind, stp, $urandom_range(0, 3), id);
            model_run();
            run_session(to);
            checks++;
            if (to || first_diff() != -1) begin
                errors++;
                $display("FAIL rand%0d_txlog kind %0d step %0d got %0d bytes need %0d timeout %0d",
                         it, kind, stp, tx_log.size(), exp_log.size(), to);
            end
            checks++;
            if ({oDone, oFail, oEn, oWheel, oRetries} !== exp_status()) begin
                errors++;
                $display("FAIL rand%0d_status kind %0d got %b need %b",
                         it, kind, {oDone, oFail, oEn, oWheel, oRetries}, exp_status());
            end
            checks++;
            if (late_drop != 0) begin
                errors++;
                $display("FAIL rand%0d_txreq_drop got %0d late need 0", it, late_drop);
            end
        end
    endtask

    initial begin
        RESET    = 1'b1;
        iStart   = 1'b0;
        iTxDone  = 1'b0;
        iTxErr   = 1'b0;
        iRxValid = 1'b0;
        iRxByte  = 8'h00;
        test_reset();
        test_wheel();
        test_plain();
        test_resend();
        test_no_reply();
        test_bat_retry();
        test_reset_mid();
        test_restart();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
